// File: rtl/gate_activation.sv
// gate_activation: captures a pre-activation vector and its bias, then applies a saturating
// bias add and a piecewise-linear sigmoid or tanh one element per cycle. The finished vector
// is published all at once on activeOut with a one-cycle outValid pulse.
module gate_activation #(
    parameter int NROW     = 16,
    parameter int QN       = 6,
    parameter int QM       = 11,
    parameter int ACT_TYPE = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [(QN+QM+1)*NROW-1:0]    dataIn,
    input  logic [(QN+QM+1)*NROW-1:0]    biasIn,
    input  logic                         dataValid,
    output logic                         busy,
    output logic                         outValid,
    output logic [(QN+QM+1)*NROW-1:0]    activeOut
);

    localparam int BITWIDTH     = QN + QM + 1;
    localparam int IDX_BITWIDTH = (NROW > 1) ? $clog2(NROW) : 1;
    localparam int VECW         = BITWIDTH * NROW;
    localparam int MAX_V        = (1 <<< (BITWIDTH - 1)) - 1;
    localparam int MIN_V        = -(1 <<< (BITWIDTH - 1));

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                    state_q;
    logic [IDX_BITWIDTH-1:0]   idx_q;
    logic [VECW-1:0]           data_q;
    logic [VECW-1:0]           bias_q;
    logic [VECW-1:0]           result_q;
    logic [VECW-1:0]           active_q;
    logic                      out_valid_q;

    logic [BITWIDTH-1:0]       cur_x;
    logic [BITWIDTH-1:0]       cur_b;
    logic [BITWIDTH-1:0]       cur_y;

    function automatic int sat(input int v);
        if (v > MAX_V) return MAX_V;
        if (v < MIN_V) return MIN_V;
        return v;
    endfunction

    // Bias add, optional doubling for tanh, then the sigmoid segments on |z| (Q6.11 constants).
    function automatic logic [BITWIDTH-1:0] act_elem(input logic [BITWIDTH-1:0] x,
                                                     input logic [BITWIDTH-1:0] b);
        int s;
        int z;
        int a;
        int y;
        int r;
        s = sat(int'($signed(x)) + int'($signed(b)));
        z = (ACT_TYPE == 1) ? sat(2 * s) : s;
        // The most negative value has no positive twin; fold it onto the maximum.
        if (z == MIN_V)  a = MAX_V;
        else if (z < 0)  a = -z;
        else             a = z;
        if (a >= 10240)      y = 2048;
        else if (a >= 4864)  y = (a >>> 5) + 1728;
        else if (a >= 2048)  y = (a >>> 3) + 1280;
        else                 y = (a >>> 2) + 1024;
        if (z < 0) y = 2048 - y;
        r = (ACT_TYPE == 1) ? (2 * y - 2048) : y;
        return BITWIDTH'(r);
    endfunction

    // Select the element addressed by idx and compute its activation.
    always_comb begin
        cur_x = data_q[idx_q*BITWIDTH +: BITWIDTH];
        cur_b = bias_q[idx_q*BITWIDTH +: BITWIDTH];
        cur_y = act_elem(cur_x, cur_b);
    end

    // Control FSM: capture, walk the elements, then publish the full vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            data_q      <= '0;
            bias_q      <= '0;
            result_q    <= '0;
            active_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (dataValid) begin
                        data_q  <= dataIn;
                        bias_q  <= biasIn;
                        idx_q   <= '0;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    result_q[idx_q*BITWIDTH +: BITWIDTH] <= cur_y;
                    if (idx_q == IDX_BITWIDTH'(NROW - 1)) begin
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    active_q    <= result_q;
                    out_valid_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = (state_q != StIdle);
    assign outValid  = out_valid_q;
    assign activeOut = active_q;

endmodule

// File: tb/tb_gate_activation.sv
// Bench for gate_activation: a sigmoid and a tanh instance share stimulus; a vector-level
// timing model (countdown from capture to publish) predicts busy, outValid and activeOut.
module tb_gate_activation;

    localparam int NROW = 16;
    localparam int QN   = 6;
    localparam int QM   = 11;
    localparam int BW   = QN + QM + 1;
    localparam int VW   = BW * NROW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dv = 1'b0;
    logic [VW-1:0] din = '0;
    logic [VW-1:0] bin = '0;

    logic          busy_s, ov_s, busy_t, ov_t;
    logic [VW-1:0] act_s, act_t;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    gate_activation #(.NROW(NROW), .QN(QN), .QM(QM), .ACT_TYPE(0)) dut_s (
        .clk(clk), .reset(reset), .dataIn(din), .biasIn(bin), .dataValid(dv),
        .busy(busy_s), .outValid(ov_s), .activeOut(act_s)
    );

    gate_activation #(.NROW(NROW), .QN(QN), .QM(QM), .ACT_TYPE(1)) dut_t (
        .clk(clk), .reset(reset), .dataIn(din), .biasIn(bin), .dataValid(dv),
        .busy(busy_t), .outValid(ov_t), .activeOut(act_t)
    );

    // ---------------- reference model ----------------
    function automatic int clamp18(input int v);
        return (v > 131071) ? 131071 : ((v < -131072) ? -131072 : v);
    endfunction

    function automatic int model_act(input int x, input int b, input bit is_tanh);
        int s, z, a, y;
        bit neg;
        s   = clamp18(x + b);
        z   = is_tanh ? clamp18(s * 2) : s;
        neg = (z < 0);
        a   = neg ? ((z == -131072) ? 131071 : -z) : z;
        if (a >= 10240)      y = 2048;
        else if (a >= 4864)  y = a / 32 + 1728;
        else if (a >= 2048)  y = a / 8 + 1280;
        else                 y = a / 4 + 1024;
        if (neg) y = 2048 - y;
        return is_tanh ? (2 * y - 2048) : y;
    endfunction

    function automatic logic [VW-1:0] model_vec(input logic [VW-1:0] d, input logic [VW-1:0] b,
                                                input bit is_tanh);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < NROW; k++) begin
            v[k*BW +: BW] = BW'(model_act(int'($signed(d[k*BW +: BW])),
                                          int'($signed(b[k*BW +: BW])), is_tanh));
        end
        return v;
    endfunction

    // Cycles remaining until publish; 0 means the block can accept a new vector.
    int            cnt = 0;
    bit            exp_ov = 1'b0;
    logic [VW-1:0] pend_s = '0, pend_t = '0, exp_act_s = '0, exp_act_t = '0;

    always @(posedge clk) begin
        if (reset) begin
            cnt       = 0;
            exp_ov    = 1'b0;
            exp_act_s = '0;
            exp_act_t = '0;
        end else begin
            exp_ov = (cnt == 1);
            if (cnt == 1) begin
                exp_act_s = pend_s;
                exp_act_t = pend_t;
            end
            if (cnt > 0) begin
                cnt = cnt - 1;
            end else if (dv) begin
                pend_s = model_vec(din, bin, 1'b0);
                pend_t = model_vec(din, bin, 1'b1);
                cnt    = NROW + 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [VW-1:0] act,
                             input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int elem(input logic [VW-1:0] v, input int k);
        return int'($signed(v[k*BW +: BW]));
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check_bit("busy_s", busy_s, cnt > 0);
            check_bit("busy_t", busy_t, cnt > 0);
            check_bit("outValid_s", ov_s, exp_ov);
            check_bit("outValid_t", ov_t, exp_ov);
            check_vec("activeOut_s", act_s, exp_act_s);
            check_vec("activeOut_t", act_t, exp_act_t);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_elem(input int k, input int x, input int b);
        din[k*BW +: BW] = BW'(x);
        bin[k*BW +: BW] = BW'(b);
    endtask

    task automatic clear_vec();
        din = '0;
        bin = '0;
    endtask

    // Pulse dataValid for one cycle, then wait (bounded) for outValid on the sigmoid instance.
    task automatic run_vec(output int lat, output int busy_n);
        @(negedge clk);
        dv = 1'b1;
        @(negedge clk);
        dv     = 1'b0;
        lat    = 1;
        busy_n = busy_s ? 1 : 0;
        while (!ov_s && lat < 60) begin
            @(negedge clk);
            lat++;
            if (busy_s) busy_n++;
        end
        if (!ov_s) begin
            errors++;
            checks++;
            $display("FAIL run_vec_timeout: got no outValid expected pulse at %0t", $time);
        end
    endtask

    int lat, busy_n, pulses, gap;
    logic [VW-1:0] held;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state, pinned literally.
        check_bit("reset_busy", busy_s, 1'b0);
        check_bit("reset_outValid", ov_s, 1'b0);
        check_vec("reset_activeOut", act_s, '0);

        // All-zero vector: timing and mid-point values.
        clear_vec();
        run_vec(lat, busy_n);
        check_int("latency", lat, NROW + 2);
        check_int("busy_cycles", busy_n, NROW + 1);
        check_int("zero_sig_e0", elem(act_s, 0), 1024);
        check_int("zero_sig_e15", elem(act_s, 15), 1024);
        check_int("zero_tanh_e7", elem(act_t, 7), 0);

        // Sigmoid segment pattern.
        clear_vec();
        set_elem(0, 2048, 0);
        set_elem(1, -2048, 0);
        set_elem(2, 6144, 0);
        set_elem(3, 12288, 0);
        set_elem(4, -12288, 0);
        run_vec(lat, busy_n);
        check_int("sig_e0", elem(act_s, 0), 1536);
        check_int("sig_e1", elem(act_s, 1), 512);
        check_int("sig_e2", elem(act_s, 2), 1920);
        check_int("sig_e3", elem(act_s, 3), 2048);
        check_int("sig_e4", elem(act_s, 4), 0);
        check_int("sig_e5", elem(act_s, 5), 1024);

        // Saturation at both ends.
        clear_vec();
        set_elem(0, 131071, 1);
        set_elem(1, -131072, -1);
        run_vec(lat, busy_n);
        check_int("sat_hi_sig", elem(act_s, 0), 2048);
        check_int("sat_lo_sig", elem(act_s, 1), 0);
        check_int("sat_hi_tanh", elem(act_t, 0), 2048);
        check_int("sat_lo_tanh", elem(act_t, 1), -2048);

        // Tanh pattern.
        clear_vec();
        set_elem(1, 1024, 0);
        set_elem(2, -1024, 0);
        set_elem(3, 20480, 0);
        run_vec(lat, busy_n);
        check_int("tanh_e0", elem(act_t, 0), 0);
        check_int("tanh_e1", elem(act_t, 1), 1024);
        check_int("tanh_e2", elem(act_t, 2), -1024);
        check_int("tanh_e3", elem(act_t, 3), 2048);

        // dataValid re-pulsed during CALC is ignored.
        clear_vec();
        set_elem(0, 2048, 0);
        @(negedge clk);
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        repeat (5) @(negedge clk);
        set_elem(0, -12288, 0);
        dv = 1'b1;
        @(negedge clk);
        dv     = 1'b0;
        pulses = 0;
        held   = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ov_s) begin
                pulses++;
                held = act_s;
            end
        end
        check_int("repulse_count", pulses, 1);
        check_int("repulse_value", elem(held, 0), 1536);

        // Reset while processing element 5 aborts the vector.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_vec();
        set_elem(0, 6144, 0);
        @(negedge clk);
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ov_s) pulses++;
        end
        check_int("abort_pulses", pulses, 0);
        check_vec("abort_activeOut", act_s, '0);

        // Back-to-back: B presented on the edge where A's outValid falls.
        clear_vec();
        set_elem(0, 2048, 0);
        run_vec(lat, busy_n);
        check_int("b2b_A_e0", elem(act_s, 0), 1536);
        clear_vec();
        set_elem(0, -2048, 0);
        dv  = 1'b1;
        @(negedge clk);
        dv  = 1'b0;
        gap = 1;
        while (!ov_s && gap < 60) begin
            @(negedge clk);
            gap++;
        end
        check_int("b2b_gap", gap, NROW + 2);
        check_int("b2b_B_e0", elem(act_s, 0), 512);

        // Randomized traffic: dataValid toggles freely, model tracks capture/drop.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            dv = ($urandom_range(0, 3) == 0);
            if (dv) begin
                for (int k = 0; k < NROW; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_elem(k, int'($signed(BW'($urandom()))), int'($signed(BW'($urandom()))));
                    end else begin
                        set_elem(k, int'($urandom_range(0, 32768)) - 16384,
                                 int'($urandom_range(0, 4096)) - 2048);
                    end
                end
            end
            if ($urandom_range(0, 299) == 0) reset = 1'b1;
            else reset = 1'b0;
        end
        dv    = 1'b0;
        reset = 1'b0;
        repeat (NROW + 4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
